// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 burst sequencer and its pattern generator.
package prbs_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, DONE} state_e;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [14:0] PRBS_SEED      = 15'h7ABC;
  localparam int          HDR_CNT_W      = 10;

endpackage

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer: holds the PRBS generator in reset while idle, releases it for
// 4*n header bytes plus cfg_len payload bytes, and tags each valid output byte.
//
// state | meaning
// IDLE  | generator held in reset, accepting a burst configuration
// LOAD  | one reset cycle with the new configuration stable on gen_*
// HDR   | generator running, emitting header bytes
// PAY   | generator running, emitting PRBS payload bytes
// DONE  | final byte on the generator output, burst counted
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int PAYLOAD_W = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [31:0]          cfg_seq,
  input  logic [7:0]           cfg_n,
  input  logic [PAYLOAD_W-1:0] cfg_len,
  input  logic                 abort,
  output logic                 gen_rst,
  output logic [31:0]          gen_seq,
  output logic [7:0]           gen_n,
  output logic                 byte_valid,
  output logic                 hdr_phase,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_W-1:0]     burst_cnt
);

  state_e                 state_q, state_d;
  logic [HDR_CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [PAYLOAD_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [31:0]            seq_q, seq_d;
  logic [7:0]             n_q, n_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   aborted_q, aborted_d;
  logic                   bv_q, bv_d;
  logic                   hp_q, hp_d;
  logic                   abort_hit;
  logic [7:0]             n_eff;

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    seq_d     = seq_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;
    // A zero repeat count still needs one header word: the generator cannot skip it.
    n_eff     = (cfg_n == 8'd0) ? 8'd1 : cfg_n;
    abort_hit = abort && (state_q inside {LOAD, HDR, PAY});

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          seq_d     = cfg_seq;
          n_d       = n_eff;
          hdr_cnt_d = HDR_CNT_W'(n_eff) * HDR_CNT_W'(BYTES_PER_WORD);
          pay_cnt_d = cfg_len;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = HDR;
      HDR: begin
        hdr_cnt_d = hdr_cnt_q - HDR_CNT_W'(1);
        if (hdr_cnt_q == HDR_CNT_W'(1))
          state_d = (pay_cnt_q == '0) ? DONE : PAY;
      end
      PAY: begin
        pay_cnt_d = pay_cnt_q - PAYLOAD_W'(1);
        if (pay_cnt_q == PAYLOAD_W'(1)) state_d = DONE;
      end
      DONE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_hit) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end

    // Valid/phase trail the state by one cycle to line up with the generator's output register.
    bv_d = (state_q inside {HDR, PAY}) && !abort_hit;
    hp_d = (state_q == HDR) && !abort_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      seq_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      bv_q      <= 1'b0;
      hp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      seq_q     <= seq_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      bv_q      <= bv_d;
      hp_q      <= hp_d;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign gen_rst    = (state_q == IDLE) || (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign gen_seq    = seq_q;
  assign gen_n      = n_q;
  assign byte_valid = bv_q;
  assign hdr_phase  = hp_q;
  assign aborted    = aborted_q;
  assign burst_cnt  = cnt_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: burst-level reference model checked every cycle, a
// behavioural PRBS generator on gen_*, and directed scenarios with literal expectations.
module tb_prbs_burst_ctrl;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_seq = '0;
  logic [7:0]  cfg_n = '0;
  logic [15:0] cfg_len = '0;
  logic        abort = 1'b0;
  logic        cfg_ready, gen_rst, byte_valid, hdr_phase, busy, done, aborted;
  logic [31:0] gen_seq;
  logic [7:0]  gen_n;
  logic [7:0]  burst_cnt;

  prbs_burst_ctrl #(.PAYLOAD_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_seq(cfg_seq), .cfg_n(cfg_n), .cfg_len(cfg_len), .abort(abort),
    .gen_rst(gen_rst), .gen_seq(gen_seq), .gen_n(gen_n), .byte_valid(byte_valid),
    .hdr_phase(hdr_phase), .busy(busy), .done(done), .aborted(aborted),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Behavioural generator: header words MSB byte first, then PRBS-15 bytes.
  logic [7:0]  gen_byte = '0;
  int          g_k = 0;
  logic [14:0] g_lfsr = PRBS_SEED;
  always @(posedge clk) begin
    logic [7:0] tmp;
    logic       fb;
    tmp = '0;
    if (gen_rst) begin
      g_k = 0;
      g_lfsr = PRBS_SEED;
      gen_byte <= 8'h00;
    end else begin
      if (g_k < 4 * int'(gen_n)) begin
        gen_byte <= gen_seq[31 - 8*(g_k % 4) -: 8];
      end else begin
        for (int b = 0; b < 8; b++) begin
          fb = g_lfsr[14] ^ g_lfsr[13];
          g_lfsr = {g_lfsr[13:0], fb};
          tmp = {tmp[6:0], fb};
        end
        gen_byte <= tmp;
      end
      g_k++;
    end
  end

  // Reference model: cycle position m_rel within the burst (0 = idle, 1 = load cycle).
  int          m_rel = 0, m_L = 0, m_hl = 0;
  logic [31:0] m_seq = '0;
  logic [7:0]  m_n = '0, m_cnt = '0;
  logic        m_ab = 1'b0, m_live = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_rel = 0; m_cnt = '0; m_seq = '0; m_n = '0; m_ab = 1'b0;
    end else begin
      m_ab = 1'b0;
      if (m_rel == 0) begin
        if (cfg_valid) begin
          m_seq = cfg_seq;
          m_n   = (cfg_n == 8'd0) ? 8'd1 : cfg_n;
          m_hl  = 4 * int'(m_n);
          m_L   = m_hl + int'(cfg_len);
          m_rel = 1;
        end
      end else if (abort && m_rel <= m_L + 1) begin
        m_rel = 0; m_ab = 1'b1;
      end else if (m_rel == m_L + 2) begin
        m_rel = 0; m_cnt = m_cnt + 8'd1;
      end else begin
        m_rel++;
      end
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cfg_ready",  cfg_ready,  m_rel == 0);
      chk("busy",       busy,       m_rel != 0);
      chk("gen_rst",    gen_rst,    m_rel < 2);
      chk("byte_valid", byte_valid, m_rel >= 3 && m_rel <= m_L + 2);
      chk("hdr_phase",  hdr_phase,  m_rel >= 3 && m_rel <= m_hl + 2);
      chk("done",       done,       m_rel != 0 && m_rel == m_L + 2);
      chk("aborted",    aborted,    m_ab);
      chk("burst_cnt",  burst_cnt,  m_cnt);
      chk("gen_seq",    gen_seq,    m_seq);
      chk("gen_n",      gen_n,      m_n);
    end
  end

  int         nbytes, first_cyc, done_byte, nh;
  logic [7:0] hb [16];

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one burst from IDLE and observe it until busy drops.
  task automatic burst(input logic [31:0] seq, input logic [7:0] n, input logic [15:0] len);
    cfg_seq = seq; cfg_n = n; cfg_len = len; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    nbytes = 0; nh = 0; first_cyc = 0; done_byte = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (byte_valid) begin
        nbytes++;
        if (first_cyc == 0) first_cyc = c;
        if (hdr_phase && nh < 16) begin hb[nh] = gen_byte; nh++; end
      end
      if (done) done_byte = nbytes;
      if (c > 2 && !busy) break;
    end
    chk("burst_end_busy", busy, 1'b0);
  endtask

  initial begin
    int rdy_bad, d, cnt0;
    logic done7;

    repeat (3) step();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_gen_rst", gen_rst, 1'b1);
    chk("rst_cnt", burst_cnt, 8'd0);
    rst_n = 1'b1;
    step();

    // Basic burst
    burst(32'hDEADBEEF, 8'd2, 16'd3);
    chk("basic_bytes", nbytes, 11);
    chk("basic_first", first_cyc, 3);
    chk("basic_done", done_byte, 11);
    chk("basic_nhdr", nh, 8);
    chk("basic_h0", hb[0], 8'hDE); chk("basic_h1", hb[1], 8'hAD);
    chk("basic_h2", hb[2], 8'hBE); chk("basic_h3", hb[3], 8'hEF);
    chk("basic_h4", hb[4], 8'hDE); chk("basic_h7", hb[7], 8'hEF);
    chk("basic_cnt", burst_cnt, 8'd1);
    chk("basic_gen_n", gen_n, 8'd2);
    step();

    // Zero lengths
    burst(32'hDEADBEEF, 8'd0, 16'd0);
    chk("zero_gen_n", gen_n, 8'd1);
    chk("zero_bytes", nbytes, 4);
    chk("zero_done", done_byte, 4);
    chk("zero_h0", hb[0], 8'hDE); chk("zero_h3", hb[3], 8'hEF);
    chk("zero_cnt", burst_cnt, 8'd2);
    step();

    // Abort on the third payload cycle
    cfg_seq = 32'h01234567; cfg_n = 8'd4; cfg_len = 16'd100; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (19) step();
    abort = 1'b1;
    @(negedge clk);
    chk("ab_pay_valid", byte_valid, 1'b1);
    chk("ab_pay_phase", hdr_phase, 1'b0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_pulse", aborted, 1'b1);
    chk("ab_valid", byte_valid, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_gen_rst", gen_rst, 1'b1);
    chk("ab_cnt", burst_cnt, 8'd2);
    @(negedge clk);
    chk("ab_pulse_end", aborted, 1'b0);
    step();

    // Back-to-back with cfg_valid held
    cfg_seq = 32'hA5A5_0F0F; cfg_n = 8'd1; cfg_len = 16'd1; cfg_valid = 1'b1;
    step();
    rdy_bad = 0; done7 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (cfg_ready) rdy_bad++;
      if (i == 7) done7 = done;
    end
    chk("b2b_ready_low", rdy_bad, 0);
    chk("b2b_done7", done7, 1'b1);
    @(negedge clk);
    chk("b2b_idle_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_load", busy, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("b2b_cnt", burst_cnt, 8'd4);
    step();

    // Reset during header
    cfg_seq = 32'h1122_3344; cfg_n = 8'd2; cfg_len = 16'd5; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready", cfg_ready, 1'b1);
    chk("mr_busy", busy, 1'b0);
    chk("mr_gen_rst", gen_rst, 1'b1);
    chk("mr_valid", byte_valid, 1'b0);
    chk("mr_seq", gen_seq, 32'h0);
    chk("mr_n", gen_n, 8'h0);
    chk("mr_cnt", burst_cnt, 8'd0);
    step();

    // Counter wrap over 256 bursts
    cfg_seq = 32'hCAFE_F00D; cfg_n = 8'd1; cfg_len = 16'd0; cfg_valid = 1'b1;
    d = 0; cnt0 = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        d++;
        if (d == 256) begin
          cnt0 = int'(burst_cnt);
          cfg_valid = 1'b0;
          break;
        end
      end
    end
    chk("wrap_dones", d, 256);
    chk("wrap_pre", cnt0, 255);
    @(negedge clk);
    chk("wrap_cnt", burst_cnt, 8'd0);
    chk("wrap_idle", busy, 1'b0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer for the byte-wide PRBS-15 pattern generator. It accepts a burst configuration over a valid/ready handshake and holds the generator in reset while idle. It then releases the generator for exactly 4*n header bytes plus cfg_len PRBS payload bytes, and flags each valid byte and its phase for the downstream pattern detector. It also counts completed bursts and supports abort.

Parameters:
PAYLOAD_W, 16, width of cfg_len and the payload down-counter
CNT_W, 8, width of burst_cnt (wraps)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
cfg_valid  in  1  burst request
cfg_ready  out  1  high only in IDLE
cfg_seq  in  32  header word, emitted MSB byte first
cfg_n  in  8  header word repetitions
cfg_len  in  PAYLOAD_W  PRBS payload byte count
abort  in  1  terminate current burst
gen_rst  out  1  active-high reset to generator
gen_seq  out  32  registered copy of cfg_seq
gen_n  out  8  registered copy of effective n
byte_valid  out  1  generator out byte this cycle belongs to the burst
hdr_phase  out  1  qualifies byte_valid: 1 = header byte, 0 = payload byte
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, coincident with last valid byte
aborted  out  1  one-cycle pulse after abort accepted
burst_cnt  out  CNT_W  completed (non-aborted) bursts, wraps 2^CNT_W-1 -> 0

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state=IDLE, gen_rst=1, gen_seq=0, gen_n=0, byte_valid=0, hdr_phase=0, done=0, aborted=0, burst_cnt=0, and clears all counters. It overrides every other input, including mid-burst.
- States: IDLE, LOAD, HDR, PAY, DONE.
- IDLE: cfg_ready=1, gen_rst=1.
  - On cfg_valid: capture gen_seq=cfg_seq, gen_n=(cfg_n==0 ? 1 : cfg_n), hdr_cnt=4*gen_n (10-bit), pay_cnt=cfg_len, then go to LOAD.
  - cfg_n=0 is coerced to 1 because the generator cannot skip its header.
- LOAD: gen_rst=1 for exactly one cycle with the new config stable, then go to HDR.
- HDR: gen_rst=0.
  - hdr_cnt decrements each cycle.
  - When hdr_cnt reaches 1, go to PAY, or to DONE if pay_cnt==0.
- PAY: gen_rst=0.
  - pay_cnt decrements each cycle.
  - When pay_cnt reaches 1, go to DONE.
- DONE: gen_rst=0, done=1, burst_cnt+1, then go to IDLE (gen_rst=1 again).
- byte_valid and hdr_phase are registered one cycle behind state, matching the generator's registered output:
  - byte_valid(t) = (state(t-1) in {HDR, PAY}).
  - hdr_phase(t) = (state(t-1)==HDR).
  - hdr_phase is forced 0 whenever byte_valid=0.
- Latency: handshake at edge E0 puts LOAD in cycle 1; the first valid byte is in cycle 3; byte_valid stays high for exactly 4*n+cfg_len consecutive cycles; done accompanies the final byte.
- cfg_ready=0 in every state except IDLE. cfg_valid is ignored outside IDLE and never queued.
- Abort:
  - Sampled only in LOAD, HDR and PAY.
  - Next state is IDLE, with gen_rst=1 and aborted=1 for one cycle.
  - The byte_valid register is cleared, so no valid byte follows the abort cycle.
  - No done pulse and no burst_cnt increment.
  - Abort in IDLE or DONE is ignored. In DONE, done takes priority and the burst completes.
- cfg_valid in the same cycle as the DONE->IDLE transition is not accepted. The earliest acceptance is the following IDLE cycle, giving at least two gen_rst=1 cycles between bursts.
- burst_cnt at 2^CNT_W-1 wraps to 0 on the next done.

Decomposition:
- Shared package prbs_pkg holds:
  - state enum {IDLE, LOAD, HDR, PAY, DONE}
  - BYTES_PER_WORD=4
  - PRBS_SEED=15'h7ABC
  - HDR_CNT_W=10
- No sub-module is needed. One always block handles state and counters; one registered output stage handles byte_valid and hdr_phase.

Test Plan:
- Basic burst: bench connects gen_* to the generator; cfg_seq=32'hDEADBEEF, n=2, len=3 -> byte_valid high 11 cycles starting 2 cycles after handshake. Bytes are DE AD BE EF DE AD BE EF with hdr_phase=1, then 3 PRBS bytes with hdr_phase=0. done is on byte 11 and burst_cnt=1.
- Zero lengths: cfg_n=0, len=0 -> gen_n=1, exactly 4 valid bytes DE AD BE EF, done on the 4th.
- Abort: seq=32'h01234567, n=4, len=100, abort asserted on the 3rd PAY cycle -> aborted pulse, byte_valid low from the next cycle, busy=0, burst_cnt unchanged, gen_rst=1.
- Back-to-back: cfg_valid held high for two bursts (n=1, len=1) -> second handshake occurs one cycle after DONE; cfg_ready=0 throughout the first burst; burst_cnt=2.
- Reset mid-HDR: rst_n=0 for one edge during the header -> next cycle all outputs at reset values, state IDLE, cfg_ready=1.
- Wrap: 256 bursts of n=1, len=0 -> burst_cnt returns to 0 after the 256th done.
